// File: rtl/lsu_affine_ctx_pkg.sv
// ============================================================================
// Module : lsu_affine_ctx_pkg
// Brief  : Instruction field layout and AGU config packing shared by the LSU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_affine_ctx_pkg;

  localparam int LSU_INST_W    = 11;
  localparam int LSU_SEL_W     = 2;

  localparam int REN_BIT       = 10;
  localparam int WEN_BIT       = 9;
  localparam int R_SEL_LSB     = 7;
  localparam int W_SEL_LSB     = 5;
  localparam int ADDR_SEL_LSB  = 3;
  localparam int STORE_SEL_BIT = 0;

  // agu_cfg is packed {base, stride_i, stride_j, bound_i, bound_j}, MSB first
  function automatic int cfg_width(input int aw, input int cw);
    return 3 * aw + 2 * cw;
  endfunction

  function automatic int cfg_base_lsb(input int aw, input int cw);
    return 2 * cw + 2 * aw;
  endfunction

  function automatic int cfg_stride_i_lsb(input int aw, input int cw);
    return 2 * cw + aw;
  endfunction

  function automatic int cfg_stride_j_lsb(input int cw);
    return 2 * cw;
  endfunction

  function automatic int cfg_bound_i_lsb(input int cw);
    return cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_affine_ctx_agu.sv
// ============================================================================
// Module : lsu_agu
// Brief  : Two-level affine address generator advanced by accepted accesses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_agu
  import lsu_affine_ctx_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [3*ADDR_W+2*CNT_W-1:0]   cfg,
  input  logic                          accept,
  output logic [ADDR_W-1:0]             addr,
  output logic                          done
);

  localparam int BASE_LSB     = cfg_base_lsb(ADDR_W, CNT_W);
  localparam int STRIDE_I_LSB = cfg_stride_i_lsb(ADDR_W, CNT_W);
  localparam int STRIDE_J_LSB = cfg_stride_j_lsb(CNT_W);
  localparam int BOUND_I_LSB  = cfg_bound_i_lsb(CNT_W);

  logic [ADDR_W-1:0] r_base, r_stride_i, r_stride_j, r_acc_i, r_acc_j;
  logic [CNT_W-1:0]  r_bound_i, r_bound_j, r_cnt_i, r_cnt_j;
  logic              r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_stride_i <= '0;
      r_stride_j <= '0;
      r_bound_i  <= '0;
      r_bound_j  <= '0;
      r_cnt_i    <= '0;
      r_cnt_j    <= '0;
      r_acc_i    <= '0;
      r_acc_j    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // a config load restarts the sweep; a coincident access is not counted
      if (cfg_we) begin
        r_base     <= cfg[BASE_LSB +: ADDR_W];
        r_stride_i <= cfg[STRIDE_I_LSB +: ADDR_W];
        r_stride_j <= cfg[STRIDE_J_LSB +: ADDR_W];
        r_bound_i  <= cfg[BOUND_I_LSB +: CNT_W];
        r_bound_j  <= cfg[0 +: CNT_W];
        r_cnt_i    <= '0;
        r_cnt_j    <= '0;
        r_acc_i    <= '0;
        r_acc_j    <= '0;
      end else if (accept) begin
        if (r_cnt_j < r_bound_j) begin
          r_cnt_j <= r_cnt_j + CNT_W'(1);
          r_acc_j <= r_acc_j + r_stride_j;
        end else begin
          r_cnt_j <= '0;
          r_acc_j <= '0;
          if (r_cnt_i < r_bound_i) begin
            r_cnt_i <= r_cnt_i + CNT_W'(1);
            r_acc_i <= r_acc_i + r_stride_i;
          end else begin
            r_cnt_i <= '0;
            r_acc_i <= '0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign addr = r_base + r_acc_i + r_acc_j;
  assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/lsu_affine_ctx.sv
// ============================================================================
// Module : lsu_affine_ctx
// Brief  : CGRA tile LSU replaying a context buffer with affine addressing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_affine_ctx
  import lsu_affine_ctx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int SEL_W     = LSU_SEL_W,
  parameter int INST_W    = LSU_INST_W,
  parameter int CFG_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init,
  input  logic [INST_W-1:0]             inst_in,
  input  logic                          run,
  input  logic                          agu_cfg_we,
  input  logic [3*ADDR_W+2*CNT_W-1:0]   agu_cfg,
  input  logic [DATA_W-1:0]             pe_in,
  input  logic                          rd_valid,
  input  logic [DATA_W-1:0]             rd_data,
  input  logic                          mem_req_ready,
  output logic                          mem_req_valid,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [SEL_W-1:0]              r_sel,
  output logic [SEL_W-1:0]              w_sel,
  output logic [SEL_W-1:0]              addr_sel,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             lsu_to_pe,
  output logic                          stall,
  output logic                          agu_done
);

  localparam int PTR_W = $clog2(CFG_DEPTH);

  logic [INST_W-1:0] r_ctx_buf [CFG_DEPTH];
  logic [PTR_W-1:0]  r_init_ptr, r_run_ptr;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_load, r_store;
  logic              w_accept;
  logic              w_store_sel;
  logic              w_unused_rsvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CFG_DEPTH; k++) r_ctx_buf[k] <= '0;
      r_init_ptr <= '0;
    end else if (init) begin
      r_ctx_buf[r_init_ptr] <= inst_in;
      r_init_ptr            <= r_init_ptr + PTR_W'(1);
    end
  end

  // init owns the cycle; a stalled request keeps its instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst    <= '0;
      r_run_ptr <= '0;
    end else if (!init && run && !stall) begin
      r_inst    <= r_ctx_buf[r_run_ptr];
      r_run_ptr <= r_run_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load  <= '0;
      r_store <= '0;
    end else begin
      if (rd_valid) r_load <= rd_data;
      if (!stall)   r_store <= w_store_sel ? r_load : pe_in;
    end
  end

  assign mem_ren       = r_inst[REN_BIT];
  assign mem_wen       = r_inst[WEN_BIT];
  assign r_sel         = r_inst[R_SEL_LSB +: SEL_W];
  assign w_sel         = r_inst[W_SEL_LSB +: SEL_W];
  assign addr_sel      = r_inst[ADDR_SEL_LSB +: SEL_W];
  assign w_store_sel   = r_inst[STORE_SEL_BIT];
  assign w_unused_rsvd = ^r_inst[ADDR_SEL_LSB-1:STORE_SEL_BIT+1];

  assign mem_req_valid = mem_ren | mem_wen;
  assign stall         = mem_req_valid & ~mem_req_ready;
  assign w_accept      = mem_req_valid & mem_req_ready;
  assign wr_data       = r_store;
  assign lsu_to_pe     = r_load;

  lsu_agu #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_agu (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_we (agu_cfg_we),
    .cfg    (agu_cfg),
    .accept (w_accept),
    .addr   (mem_addr),
    .done   (agu_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_lsu_affine_ctx.sv
// ============================================================================
// Module : tb_lsu_affine_ctx
// Brief  : Directed, table-driven bench for lsu_affine_ctx.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_affine_ctx;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic [10:0] inst_in;
  logic        run;
  logic        agu_cfg_we;
  logic [61:0] agu_cfg;
  logic [31:0] pe_in;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        mem_req_ready;
  logic        mem_req_valid;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  r_sel;
  logic [1:0]  w_sel;
  logic [1:0]  addr_sel;
  logic [9:0]  mem_addr;
  logic [31:0] wr_data;
  logic [31:0] lsu_to_pe;
  logic        stall;
  logic        agu_done;

  int n_checks = 0;
  int n_errors = 0;

  lsu_affine_ctx u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init          (init),
    .inst_in       (inst_in),
    .run           (run),
    .agu_cfg_we    (agu_cfg_we),
    .agu_cfg       (agu_cfg),
    .pe_in         (pe_in),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_req_ready (mem_req_ready),
    .mem_req_valid (mem_req_valid),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .r_sel         (r_sel),
    .w_sel         (w_sel),
    .addr_sel      (addr_sel),
    .mem_addr      (mem_addr),
    .wr_data       (wr_data),
    .lsu_to_pe     (lsu_to_pe),
    .stall         (stall),
    .agu_done      (agu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] exp_rsel;
    logic [1:0] exp_wsel;
    logic [1:0] exp_asel;
    logic       exp_ren;
    logic       exp_wen;
  } run_vec_t;

  typedef struct {
    logic       cfg_we;
    logic       run;
    logic       ready;
    logic [9:0] exp_addr;
    logic       exp_done;
    logic       exp_stall;
    logic       exp_ren;
    logic       exp_wen;
  } sweep_vec_t;

  logic [10:0] prog [17];
  run_vec_t    run_tbl [4];
  sweep_vec_t  sweep_tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; inst_in = '0; run = 1'b0;
    agu_cfg_we = 1'b0; agu_cfg = '0; pe_in = '0; rd_valid = 1'b0;
    rd_data = '0; mem_req_ready = 1'b0;

    // e0 is written twice: the 17th write lands back on entry 0
    prog[0] = 11'h200; prog[1] = 11'h261; prog[2] = 11'h000; prog[3] = 11'h400;
    for (int k = 4; k < 16; k++) prog[k] = 11'h000;
    prog[16] = 11'h508;

    run_tbl[0] = '{2'd2, 2'd0, 2'd1, 1'b1, 1'b0};
    run_tbl[1] = '{2'd0, 2'd3, 2'd0, 1'b0, 1'b1};
    run_tbl[2] = '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    run_tbl[3] = '{2'd0, 2'd0, 2'd0, 1'b1, 1'b0};

    //                cfg   run   rdy   addr     done  stall ren   wen
    sweep_tbl[0]  = '{1'b1, 1'b0, 1'b1, 10'd100, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[1]  = '{1'b0, 1'b0, 1'b1, 10'd101, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[2]  = '{1'b0, 1'b0, 1'b1, 10'd102, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[3]  = '{1'b0, 1'b0, 1'b1, 10'd160, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[4]  = '{1'b0, 1'b0, 1'b1, 10'd161, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[5]  = '{1'b0, 1'b0, 1'b1, 10'd162, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[6]  = '{1'b0, 1'b0, 1'b1, 10'd100, 1'b1, 1'b0, 1'b1, 1'b0};
    sweep_tbl[7]  = '{1'b0, 1'b0, 1'b1, 10'd101, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[8]  = '{1'b0, 1'b1, 1'b0, 10'd101, 1'b0, 1'b1, 1'b1, 1'b0};
    sweep_tbl[9]  = '{1'b0, 1'b1, 1'b0, 10'd101, 1'b0, 1'b1, 1'b1, 1'b0};
    sweep_tbl[10] = '{1'b0, 1'b1, 1'b0, 10'd101, 1'b0, 1'b1, 1'b1, 1'b0};
    sweep_tbl[11] = '{1'b0, 1'b0, 1'b1, 10'd102, 1'b0, 1'b0, 1'b1, 1'b0};
    sweep_tbl[12] = '{1'b0, 1'b0, 1'b1, 10'd160, 1'b0, 1'b0, 1'b1, 1'b0};

    // reset state
    tick();
    tick();
    chk("rst.valid", 64'(mem_req_valid), 64'd0);
    chk("rst.rsel", 64'(r_sel), 64'd0);
    chk("rst.addr", 64'(mem_addr), 64'd0);
    chk("rst.wr_data", 64'(wr_data), 64'd0);
    chk("rst.lsu_to_pe", 64'(lsu_to_pe), 64'd0);
    chk("rst.done", 64'(agu_done), 64'd0);
    rst_n = 1'b1;
    mem_req_ready = 1'b1;
    tick();

    // fill the buffer with run held high: run must be ignored throughout
    for (int k = 0; k < 17; k++) begin
      init = 1'b1; run = 1'b1; inst_in = prog[k];
      tick();
      chk($sformatf("init[%0d].valid", k), 64'(mem_req_valid), 64'd0);
    end
    init = 1'b0;

    for (int k = 0; k < 4; k++) begin
      run = 1'b1;
      tick();
      chk($sformatf("run[%0d].ren", k), 64'(mem_ren), 64'(run_tbl[k].exp_ren));
      chk($sformatf("run[%0d].wen", k), 64'(mem_wen), 64'(run_tbl[k].exp_wen));
      chk($sformatf("run[%0d].rsel", k), 64'(r_sel), 64'(run_tbl[k].exp_rsel));
      chk($sformatf("run[%0d].wsel", k), 64'(w_sel), 64'(run_tbl[k].exp_wsel));
      chk($sformatf("run[%0d].asel", k), 64'(addr_sel), 64'(run_tbl[k].exp_asel));
    end
    for (int k = 4; k < 16; k++) begin
      tick();
      chk($sformatf("run[%0d].idle", k), 64'(mem_req_valid), 64'd0);
    end
    tick();
    chk("run.wrap.ren", 64'(mem_ren), 64'd1);
    chk("run.wrap.rsel", 64'(r_sel), 64'd2);
    run = 1'b0;

    // sweep; row 0 loads config on top of an accepted access
    for (int k = 0; k < 13; k++) begin
      agu_cfg_we    = sweep_tbl[k].cfg_we;
      agu_cfg       = {10'd100, 10'd60, 10'd1, 16'd1, 16'd2};
      run           = sweep_tbl[k].run;
      mem_req_ready = sweep_tbl[k].ready;
      tick();
      chk($sformatf("sweep[%0d].addr", k), 64'(mem_addr), 64'(sweep_tbl[k].exp_addr));
      chk($sformatf("sweep[%0d].done", k), 64'(agu_done), 64'(sweep_tbl[k].exp_done));
      chk($sformatf("sweep[%0d].stall", k), 64'(stall), 64'(sweep_tbl[k].exp_stall));
      chk($sformatf("sweep[%0d].ren", k), 64'(mem_ren), 64'(sweep_tbl[k].exp_ren));
      chk($sformatf("sweep[%0d].wen", k), 64'(mem_wen), 64'(sweep_tbl[k].exp_wen));
    end
    agu_cfg_we = 1'b0;

    // load/store path; entry 1 is a store with store_sel=1
    run = 1'b1; pe_in = 32'h1234_5678;
    tick();
    chk("ls.wen", 64'(mem_wen), 64'd1);
    chk("ls.wsel", 64'(w_sel), 64'd3);
    chk("ls.wr_pe", 64'(wr_data), 64'h1234_5678);
    run = 1'b0; rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    tick();
    chk("ls.load", 64'(lsu_to_pe), 64'hDEAD_BEEF);
    chk("ls.wr_old_load", 64'(wr_data), 64'd0);
    rd_valid = 1'b0; rd_data = 32'hCAFE_F00D;
    tick();
    chk("ls.load_hold", 64'(lsu_to_pe), 64'hDEAD_BEEF);
    chk("ls.wr_load", 64'(wr_data), 64'hDEAD_BEEF);
    mem_req_ready = 1'b0; rd_valid = 1'b1; rd_data = 32'h0BAD_F00D; pe_in = 32'h55AA_55AA;
    tick();
    chk("ls.stall", 64'(stall), 64'd1);
    chk("ls.load_in_stall", 64'(lsu_to_pe), 64'h0BAD_F00D);
    rd_valid = 1'b0;
    tick();
    chk("ls.store_hold", 64'(wr_data), 64'hDEAD_BEEF);
    chk("ls.addr_hold", 64'(mem_addr), 64'd100);
    mem_req_ready = 1'b1;
    tick();
    chk("ls.store_resume", 64'(wr_data), 64'h0BAD_F00D);
    chk("ls.addr_resume", 64'(mem_addr), 64'd101);

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(mem_req_valid), 64'd0);
    chk("arst.wsel", 64'(w_sel), 64'd0);
    chk("arst.addr", 64'(mem_addr), 64'd0);
    chk("arst.wr_data", 64'(wr_data), 64'd0);
    chk("arst.lsu_to_pe", 64'(lsu_to_pe), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("arst.addr_after", 64'(mem_addr), 64'd0);
    chk("arst.valid_after", 64'(mem_req_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_affine_ctx.md
Name: lsu_affine_ctx

Overview:
- Parametrised next-generation load/store unit for a CGRA tile.
- Holds a context buffer of per-cycle LSU instructions and replays it cyclically during run.
- Generates 2-level affine addresses (base + i*stride_i + j*stride_j) from runtime-programmed bounds and strides.
- Talks to the bank arbiter with a valid/ready request handshake (stalls on back-pressure) and captures load data only on returned-data valid.

Parameters:
- DATA_W, 32, data path width.
- ADDR_W, 10, bank-local address width.
- SEL_W, 2, bank/port select field width (r_sel, w_sel, addr_sel).
- INST_W, 11, instruction width; field layout below.
- CFG_DEPTH, 16, context buffer entries; power of two.
- CNT_W, 16, loop counter width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous assert, active-low.
- init, input, 1, write inst_in into context buffer.
- inst_in, input, INST_W, instruction word.
- run, input, 1, advance context pointer.
- agu_cfg_we, input, 1, load AGU configuration.
- agu_cfg, input, 2*ADDR_W+ADDR_W+2*CNT_W, packed {base, stride_i, stride_j, bound_i, bound_j}.
- pe_in, input, DATA_W, store data from PE.
- rd_valid, input, 1, read data return valid.
- rd_data, input, DATA_W, read data.
- mem_req_ready, input, 1, arbiter accepts request.
- mem_req_valid, output, 1, ren|wen of current instruction.
- mem_ren, output, 1, read request.
- mem_wen, output, 1, write request.
- r_sel, output, SEL_W, read source select.
- w_sel, output, SEL_W, write destination select.
- addr_sel, output, SEL_W, address bus select.
- mem_addr, output, ADDR_W, generated address.
- wr_data, output, DATA_W, store register.
- lsu_to_pe, output, DATA_W, load register.
- stall, output, 1, mem_req_valid & ~mem_req_ready.
- agu_done, output, 1, one-cycle pulse after final access of the 2-D sweep.

Behaviour:
- Reset (rst_n low, async): buffer entries, pointers, inst_r, AGU regs/counters, load_reg, store_reg, agu_done all 0. Hence every output is 0.
- Instruction fields in inst_r:
  - ren [10], wen [9], r_sel [8:7], w_sel [6:5], addr_sel [4:3], store_sel [0].
  - Bits [2:1] reserved and ignored.
- init cycle: buf[init_ptr] <= inst_in; init_ptr increments modulo CFG_DEPTH. init has priority over run when both are high (run is ignored that cycle).
- run cycle with ~stall: inst_r <= buf[run_ptr]; run_ptr increments modulo CFG_DEPTH. Outputs reflect the new instruction one cycle after run.
- run low: inst_r holds (the request repeats). Drive run low after the last context to idle; an idle entry has ren=wen=0.
- stall = 1:
  - inst_r, run_ptr, AGU counters and store_reg hold.
  - Request outputs remain stable until accepted.
- Access accepted = mem_req_valid & mem_req_ready. Only accepted accesses advance the AGU.
- mem_addr = base + acc_i + acc_j, truncated modulo 2^ADDR_W, combinational from registers.
- AGU advance on accept:
  - cnt_j < bound_j: cnt_j++, acc_j += stride_j.
  - Else cnt_j <= 0, acc_j <= 0, then:
    - cnt_i < bound_i: cnt_i++, acc_i += stride_i.
    - Else cnt_i <= 0, acc_i <= 0, agu_done <= 1 for one cycle.
  - Bounds are inclusive: (bound_i+1)*(bound_j+1) accesses per sweep, then the sweep wraps to base.
- agu_cfg_we: loads the config and clears counters/accumulators. It wins over a same-cycle accept; that access is not counted.
- Load: rd_valid => load_reg <= rd_data, else hold. lsu_to_pe = load_reg.
- Store: when ~stall, store_reg <= store_sel ? load_reg : pe_in. wr_data = store_reg.

Decomposition:
- Shared include: INST_W, field bit positions, SEL_W, and the agu_cfg packing offsets.
- Sub-module lsu_agu: 2-level counter/accumulator with accept, cfg load, done.

Test Plan:
- Reset mid-sweep: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately; mem_addr=0 after release.
- Init 3 entries (ren=1; wen=1; idle), run 4 cycles -> mem_ren, mem_wen, idle, mem_ren sequence, each one cycle after its run; run_ptr wraps at CFG_DEPTH with CFG_DEPTH writes.
- Sweep with base=100, stride_i=60, stride_j=1, bound_i=1, bound_j=2, ready=1 -> addresses 100,101,102,160,161,162,100; agu_done pulses once after 162.
- Back-pressure: mem_req_ready=0 for 3 cycles mid-sweep -> stall=1, mem_addr/inst outputs frozen; advance resumes on first accept with no skipped or duplicated address.
- Load/store: rd_valid with rd_data=0xDEADBEEF, store_sel=1 -> lsu_to_pe=0xDEADBEEF next cycle, wr_data=0xDEADBEEF the cycle after; rd_valid=0 -> load_reg holds.
- Simultaneous init+run and agu_cfg_we+accept -> run ignored; config loaded and counters zero, addr=new base.
